// File: rtl/imem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses from 0, holding the CPU in reset meanwhile.
module imem_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold
);

  localparam int               ADDR_W    = $clog2(MEM_BYTES);
  localparam logic [CNT_W-1:0] MEM_WORDS = CNT_W'(MEM_BYTES / 4);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   n_clamped;

  assign n_clamped = (num_words > MEM_WORDS) ? MEM_WORDS : num_words;

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = n_clamped;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
          state_d    = (n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (byte_valid) begin
          data_d     = {data_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
        // The final word keeps its address so the register never passes MEM_BYTES-4.
        if (word_cnt_d == n_q) begin
          state_d = abort ? S_IDLE : S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(4);
          state_d = abort ? S_IDLE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset reaches them immediately.
  assign byte_ready = (state_q == S_LOAD);
  assign wr_en      = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign cpu_hold   = (state_q != S_DONE);
  assign wr_addr    = {{(32-ADDR_W){1'b0}}, addr_q};
  assign wr_data    = data_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: assembles a byte stream into 32-bit big-endian words and writes them into instruction memory at consecutive word-aligned byte addresses starting at 0.
- The processor's fetch path reads that memory by pc (byte address, 0..4092).
- The block holds the CPU in reset while loading and signals completion.
- Sits between a host or UART byte source and the instruction memory write port.

Parameters:
- MEM_BYTES, 4096, instruction memory size in bytes (word count = MEM_BYTES/4).
- CNT_W, 11, width of the word-count input; must hold MEM_BYTES/4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- num_words  input  CNT_W  number of words to load; sampled when start is accepted
- abort  input  1  cancel an in-progress load
- byte_data  input  8  incoming program byte
- byte_valid  input  1  byte_data valid this cycle
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  32  write byte address, always a multiple of 4
- wr_data  output  32  write word
- busy  output  1  load in progress
- done  output  1  load finished successfully; level signal
- cpu_hold  output  1  hold processor in reset

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE.
  - byte_ready, wr_en, busy, done = 0.
  - wr_addr, wr_data, byte counter, word counter = 0.
  - cpu_hold = 1.
- IDLE:
  - cpu_hold = 1.
  - On start: latch n = min(num_words, MEM_BYTES/4), clear the address and counters, then go to LOAD. If n = 0, go directly to DONE instead.
- LOAD:
  - byte_ready = 1, busy = 1.
  - A byte is accepted only on a cycle where byte_valid and byte_ready are both high.
  - Big-endian packing: the first accepted byte goes to bits 31:24, then 23:16, 15:8, 7:0.
  - On the 4th accepted byte, go to WRITE.
- WRITE, exactly one cycle:
  - wr_en = 1 with the current wr_addr and the assembled wr_data.
  - byte_ready = 0; any byte_valid on this cycle is not consumed.
  - Next cycle: wr_addr += 4 and word count += 1.
  - If word count reaches n, go to DONE; otherwise go back to LOAD.
- DONE:
  - done = 1, busy = 0, cpu_hold = 0.
  - A new start re-enters the load flow: clears done and raises cpu_hold on the next cycle.
- Latency: the memory write occurs 1 cycle after the 4th byte handshake.
  - Minimum rate is 5 cycles per word when bytes arrive back-to-back.
- Outside WRITE, wr_en = 0. wr_data and wr_addr may hold stale values.
- Abort:
  - Abort in LOAD or WRITE returns to IDLE: done = 0, cpu_hold = 1.
  - A partial word is discarded.
  - If abort coincides with a WRITE cycle, that write still occurs (wr_en already high), then the block goes to IDLE.
  - Abort in IDLE or DONE has no effect.
- start while busy is ignored.
- start and abort in the same cycle in IDLE/DONE: start wins.
- Address wrap cannot occur. Clamping to MEM_BYTES/4 keeps the last write at address MEM_BYTES-4 (4092 by default).
- wr_addr reflects the address of the current or next word only; no register exceeds MEM_BYTES-4.
- Reset asserted mid-load aborts immediately and returns all outputs to their reset values.

Test Plan:
- Reset value check: assert reset, check all outputs against reset values. Release, start with num_words=2, stream bytes 8C,01,00,04,AC,02,00,08 back-to-back. Required response:
  - Write 1: wr_en at addr 0, data 0x8C010004.
  - Write 2: wr_en at addr 4, data 0xAC020008.
  - Then done=1, cpu_hold=0.
  - Exactly 2 wr_en pulses, 5 cycles apart.
- Gappy source: byte_valid toggled randomly, num_words=3. Required response:
  - Correct words at addresses 0, 4, 8.
  - No byte consumed while byte_ready=0, including WRITE cycles.
- num_words=0: start leads to DONE one cycle later, with no wr_en pulses.
- num_words=2047: clamped to 1024.
  - Last write at wr_addr=4092.
  - Total of 1024 writes.
  - done asserted afterwards.
- Abort after 6 bytes of a 4-word load. Required response:
  - 1 write, at addr 0, occurs.
  - Returns to IDLE with cpu_hold=1 and done=0.
  - A subsequent load restarts at addr 0.
- Async reset asserted mid-word, between clock edges: outputs reach their reset values before the next clk edge. start during LOAD is ignored and n is unchanged.
